// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM state
// encoding and default bank/requester geometry.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 6;
    localparam int DEF_NREQ   = 4;
    localparam int DEF_NREG   = 8;
    localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// when scanning upward from rr_ptr, wrapping at NREQ.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    // Scan from the farthest offset down so the nearest request to rr_ptr wins.
    always_comb begin
        // NOTE: combinational outputs get a default before any conditional
        // assignment so no path leaves them unassigned (which would infer a latch).
        winner  = '0;
        any_req = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NREQ]) begin
                winner  = PTR_W'((int'(rr_ptr) + i) % NREQ);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing one register bank among NREQ
// requesters. One transaction is IDLE (grant) -> WRITE (enable pulse)
// -> ACK (acknowledge pulse); every output is a flop.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREQ   = DEF_NREQ,
    parameter int NREG   = DEF_NREG,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*WIDTH-1:0]  data,
    output logic [NREQ-1:0]        ack,
    output logic                   err,
    output logic [WIDTH-1:0]       reg_in,
    output logic [NREG-1:0]        reg_enable,
    output logic                   busy
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [ADDR_W:0] NREG_L = (ADDR_W + 1)'(NREG);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic              err_pend_q, err_pend_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  reg_in_q, reg_in_d;
    logic [NREG-1:0]   reg_enable_q, reg_enable_d;
    logic              busy_q, busy_d;

    logic [PTR_W-1:0]  pick;
    logic              any_req;
    logic [ADDR_W-1:0] pick_addr;
    logic [WIDTH-1:0]  pick_data;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (pick),
        .any_req (any_req)
    );

    assign pick_addr = addr[pick*ADDR_W +: ADDR_W];
    assign pick_data = data[pick*WIDTH +: WIDTH];

    // Next-state logic: outputs are computed one state early so the flops
    // present them exactly during the WRITE and ACK cycles.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        err_pend_d   = err_pend_q;
        reg_in_d     = reg_in_q;
        ack_d        = '0;
        err_d        = 1'b0;
        reg_enable_d = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    win_d    = pick;
                    reg_in_d = pick_data;
                    if ({1'b0, pick_addr} < NREG_L) begin
                        reg_enable_d[pick_addr] = 1'b1;
                        err_pend_d              = 1'b0;
                    end else begin
                        err_pend_d = 1'b1;
                    end
                    state_d = WRITE;
                end
            end
            WRITE: begin
                ack_d[win_q] = 1'b1;
                err_d        = err_pend_q;
                rr_ptr_d     = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
                state_d      = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, pointer, latches and output flops; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            err_pend_q   <= 1'b0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            reg_in_q     <= '0;
            reg_enable_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            err_pend_q   <= err_pend_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            reg_in_q     <= reg_in_d;
            reg_enable_q <= reg_enable_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign reg_in     = reg_in_q;
    assign reg_enable = reg_enable_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: two instances (8- and 6-register
// banks) share stimulus; each has a monitor that pops the expected
// transaction whenever its ack pulses.
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    localparam int WIDTH  = 6;
    localparam int NREQ   = 4;
    localparam int NREG   = 8;
    localparam int NREG_S = 6;
    localparam int ADDR_W = 3;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req   = '0;
    logic [NREQ*ADDR_W-1:0] addr  = '0;
    logic [NREQ*WIDTH-1:0]  data  = '0;

    logic [NREQ-1:0]   ack_a, ack_b;
    logic              err_a, err_b;
    logic [WIDTH-1:0]  rin_a, rin_b;
    logic [NREG-1:0]   en_a;
    logic [NREG_S-1:0] en_b;
    logic              busy_a, busy_b;

    always #5 clk = ~clk;

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .data(data),
        .ack(ack_a), .err(err_a), .reg_in(rin_a), .reg_enable(en_a), .busy(busy_a)
    );

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG_S), .ADDR_W(ADDR_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .data(data),
        .ack(ack_b), .err(err_b), .reg_in(rin_b), .reg_enable(en_b), .busy(busy_b)
    );

    logic [NREQ-1:0]  ack_w [2];
    logic             err_w [2];
    logic [WIDTH-1:0] rin_w [2];
    logic [NREG-1:0]  en_w  [2];

    assign ack_w[0] = ack_a;
    assign ack_w[1] = ack_b;
    assign err_w[0] = err_a;
    assign err_w[1] = err_b;
    assign rin_w[0] = rin_a;
    assign rin_w[1] = rin_b;
    assign en_w[0]  = en_a;
    assign en_w[1]  = {2'b00, en_b};

    typedef struct {
        int idx;
        int a;
        int d;
        bit e;
        int gap;
    } exp_t;

    exp_t exp_q [2][$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ack_cnt [2] = '{0, 0};

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    // Push the expected outcome for requester idx using its current addr/data.
    task automatic expect_txn(input int idx, input int gap);
        exp_t e;
        e.idx = idx;
        e.a   = int'(addr[idx*ADDR_W +: ADDR_W]);
        e.d   = int'(data[idx*WIDTH +: WIDTH]);
        e.gap = gap;
        e.e   = (e.a >= NREG);
        exp_q[0].push_back(e);
        e.e   = (e.a >= NREG_S);
        exp_q[1].push_back(e);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic [NREG-1:0]  en_acc    = '0;
        int               en_cyc    = 0;
        logic [WIDTH-1:0] data_seen = '0;
        int               last_ack  = 0;

        always @(negedge clk) begin : mon
            exp_t e;
            if (!rst_n) begin
                en_acc = '0;
                en_cyc = 0;
            end else begin
                if (en_w[g] != '0) begin
                    en_acc    = en_acc | en_w[g];
                    en_cyc++;
                    data_seen = rin_w[g];
                end
                if (ack_w[g] != '0) begin
                    ack_cnt[g]++;
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("dut%0d_unexpected_ack", g), 32'(ack_w[g]), 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("dut%0d_ack_req%0d", g, e.idx), 32'(ack_w[g]), 32'(1) << e.idx);
                        check($sformatf("dut%0d_err_req%0d", g, e.idx), 32'(err_w[g]), 32'(e.e));
                        check($sformatf("dut%0d_enable_req%0d", g, e.idx), 32'(en_acc),
                              e.e ? 32'd0 : (32'(1) << e.a));
                        check($sformatf("dut%0d_enable_cycles_req%0d", g, e.idx), 32'(en_cyc),
                              e.e ? 32'd0 : 32'd1);
                        if (!e.e)
                            check($sformatf("dut%0d_reg_in_req%0d", g, e.idx), 32'(data_seen), 32'(e.d));
                        if (e.gap != 0)
                            check($sformatf("dut%0d_spacing_req%0d", g, e.idx), 32'(cyc - last_ack), 32'(e.gap));
                    end
                    last_ack = cyc;
                    en_acc   = '0;
                    en_cyc   = 0;
                end
            end
        end
    end

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (ack_cnt[0] < target && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ack_cnt[0] < target)
            check({name, "_ack_timeout"}, 32'(ack_cnt[0]), 32'(target));
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (en_a == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (en_a == '0)
            check({name, "_enable_timeout"}, 32'(en_a), 32'hFF);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int base;

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        // Reset asserted while idle: every output of both instances reads zero.
        rst_n = 1'b0;
        #1;
        check("rst_ack_a", 32'(ack_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_reg_in_a", 32'(rin_a), 32'd0);
        check("rst_enable_a", 32'(en_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single write: requester 0 to register 3.
        base = ack_cnt[0];
        addr[0*ADDR_W +: ADDR_W] = 3'd3;
        data[0*WIDTH +: WIDTH]   = 6'b110011;
        req = 4'b0001;
        expect_txn(0, 0);
        @(negedge clk);
        #1 check("busy_during_txn", 32'(busy_a), 32'd1);
        wait_acks(base + 1, "single");
        req = 4'b0000;
        repeat (2) @(negedge clk);
        #1;

        // Contention with all requests held: grants 0,1,2,3,0, three cycles apart.
        pulse_reset();
        base = ack_cnt[0];
        addr = {3'd7, 3'd5, 3'd2, 3'd1};
        data = {6'h3C, 6'h0F, 6'h2A, 6'h11};
        req  = 4'b1111;
        expect_txn(0, 0);
        expect_txn(1, 3);
        expect_txn(2, 3);
        expect_txn(3, 3);
        expect_txn(0, 3);
        wait_acks(base + 5, "contention");
        req = 4'b0000;
        repeat (2) @(negedge clk);
        #1;

        // Pointer wrap: grant 3, then 4'b1001 must serve 0 before 3.
        base = ack_cnt[0];
        req = 4'b1000;
        expect_txn(3, 0);
        wait_acks(base + 1, "wrap_first");
        req = 4'b1001;
        expect_txn(0, 3);
        wait_acks(base + 2, "wrap_zero");
        req = 4'b1000;
        expect_txn(3, 3);
        wait_acks(base + 3, "wrap_three");
        req = 4'b0000;
        repeat (2) @(negedge clk);
        #1;

        // Address 7: valid in the 8-register bank, out of range for the 6-register bank.
        base = ack_cnt[0];
        addr[0*ADDR_W +: ADDR_W] = 3'd7;
        data[0*WIDTH +: WIDTH]   = 6'b101010;
        req = 4'b0001;
        expect_txn(0, 0);
        wait_acks(base + 1, "out_of_range");
        req = 4'b0000;
        repeat (2) @(negedge clk);
        #1;

        // Request dropped during WRITE: write and ack still complete.
        base = ack_cnt[0];
        addr[1*ADDR_W +: ADDR_W] = 3'd4;
        data[1*WIDTH +: WIDTH]   = 6'h15;
        req = 4'b0010;
        expect_txn(1, 0);
        wait_enable("drop");
        req = 4'b0000;
        wait_acks(base + 1, "drop");
        repeat (2) @(negedge clk);
        #1;

        // Reset during WRITE: enable drops at once, no ack; held req is re-served after release.
        base = ack_cnt[0];
        addr[2*ADDR_W +: ADDR_W] = 3'd2;
        data[2*WIDTH +: WIDTH]   = 6'h2D;
        req = 4'b0100;
        wait_enable("midrst");
        rst_n = 1'b0;
        #1;
        check("midrst_enable_a", 32'(en_a), 32'd0);
        check("midrst_enable_b", 32'(en_b), 32'd0);
        check("midrst_busy_a", 32'(busy_a), 32'd0);
        check("midrst_ack_a", 32'(ack_a), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("midrst_no_ack", 32'(ack_cnt[0]), 32'(base));
        expect_txn(2, 0);
        rst_n = 1'b1;
        wait_acks(base + 1, "midrst_reserve");
        req = 4'b0000;
        repeat (3) @(negedge clk);
        #1;

        check("pending_a", 32'(exp_q[0].size()), 32'd0);
        check("pending_b", 32'(exp_q[1].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
